// File: rtl/rca_pkg.sv
// Shared types and helpers for the round-robin ripple-carry add arbiter.
// The chaining state type is used only when ADD_ARB_CHAIN_EN is defined.
package rca_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rca_arbiter_fa.sv
// One-bit full adder cell, chained by the arbiter's adder stage into a ripple-carry adder.
module rca_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/rca_arbiter_rr.sv
// Round-robin grant logic: rotating pointer plus an owner register that pins the grant
// while it is stalled (not accepted) or while a chained sequence holds the arbiter.
module rr_arbiter
   import rca_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDW   = idw(N_REQ)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_accept,
   input  logic             i_hold,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDW-1:0]   o_grant_id,
   output logic             o_grant_vld
);

   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_own_id;
   logic             r_stall_v;
   logic [N_REQ-1:0] w_grant;
   logic [IDW-1:0]   w_gid;
   logic             w_gvld;

   // A pinned owner wins outright; under hold nobody else may be granted.
   always_comb begin
      int             v_idx;
      logic [IDW-1:0] v_sel;
      w_grant = '0;
      w_gid   = '0;
      w_gvld  = 1'b0;
      v_idx   = 0;
      v_sel   = '0;
      if ((i_hold || r_stall_v) && i_req[r_own_id]) begin
         w_gvld = 1'b1;
         w_gid  = r_own_id;
      end
      if (!w_gvld && !i_hold) begin
         for (int k = 0; k < N_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
            v_sel = IDW'(v_idx);
            if (!w_gvld && i_req[v_sel]) begin
               w_gvld = 1'b1;
               w_gid  = v_sel;
            end
         end
      end
      if (w_gvld) w_grant[w_gid] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr     <= '0;
         r_own_id  <= '0;
         r_stall_v <= 1'b0;
      end else if (w_gvld) begin
         r_own_id  <= w_gid;
         r_stall_v <= !i_accept;
         if (i_accept) r_ptr <= (w_gid == IDW'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
      end else begin
         r_stall_v <= 1'b0;
      end
   end

   assign o_grant     = w_grant;
   assign o_grant_id  = w_gid;
   assign o_grant_vld = w_gvld;

endmodule

// File: rtl/rca_arbiter.sv
// N_REQ requesters share one registered ripple-carry adder (S1 operands, S2 result), round-robin.
// Define ADD_ARB_CHAIN_EN for multi-word chaining via req_last and a carried-over carry.
module rca_arbiter
   import rca_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 4,
   localparam int IDW   = idw(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ-1:0]       req_cin,
`ifdef ADD_ARB_CHAIN_EN
   input  logic [N_REQ-1:0]       req_last,
`endif
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH:0]         res_sum,
   output logic [IDW-1:0]         res_id
);

   logic             r_run;
   logic             w_adv1;
   logic             w_adv2;
   logic             w_accept;
   logic             w_hold;
   logic [N_REQ-1:0] w_grant;
   logic [IDW-1:0]   w_gid;
   logic             w_gvld;
   logic [WIDTH-1:0] w_a_arr [N_REQ];
   logic [WIDTH-1:0] w_b_arr [N_REQ];

   logic             r_s1_v;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s1_cin;
   logic [IDW-1:0]   r_s1_id;
   logic             w_s1_cin;
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;

   logic             r_res_valid;
   logic [WIDTH:0]   r_res_sum;
   logic [IDW-1:0]   r_res_id;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
   end

   // Accepts are held off until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_run <= 1'b0;
      else      r_run <= 1'b1;
   end

   assign w_adv2    = !r_res_valid || res_ready;
   assign w_adv1    = !r_s1_v || w_adv2;
   assign w_accept  = w_gvld && w_adv1 && r_run;
   assign req_ready = w_grant & {N_REQ{w_adv1 && r_run}};

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .i_clk       (clk),
      .i_rst_n     (rst),
      .i_req       (req_valid),
      .i_accept    (w_accept),
      .i_hold      (w_hold),
      .o_grant     (w_grant),
      .o_grant_id  (w_gid),
      .o_grant_vld (w_gvld)
   );

`ifdef ADD_ARB_CHAIN_EN
   arb_state_t r_state;
   logic       r_carry_q;
   logic       r_s1_chain;

   assign w_hold   = (r_state == ARB_LOCKED);
   assign w_s1_cin = r_s1_chain ? r_carry_q : r_s1_cin;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_state <= ARB_IDLE;
      else if (w_accept) r_state <= req_last[w_gid] ? ARB_IDLE : ARB_LOCKED;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  r_carry_q <= 1'b0;
      else if (r_s1_v && w_adv2) r_carry_q <= w_carry[WIDTH];
   end

   // A beat accepted while locked continues the previous beat's sum.
   always_ff @(posedge clk) begin
      if (w_accept) r_s1_chain <= w_hold;
   end
`else
   assign w_hold   = 1'b0;
   assign w_s1_cin = r_s1_cin;
`endif

   // ---- S1: operand stage ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_s1_v <= 1'b0;
      else if (w_adv1) r_s1_v <= w_accept;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_a   <= w_a_arr[w_gid];
         r_s1_b   <= w_b_arr[w_gid];
         r_s1_cin <= req_cin[w_gid];
         r_s1_id  <= w_gid;
      end
   end

   assign w_carry[0] = w_s1_cin;
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      rca_fa u_fa (
         .i_a (r_s1_a[gi]),
         .i_b (r_s1_b[gi]),
         .i_c (w_carry[gi]),
         .o_s (w_sum[gi]),
         .o_c (w_carry[gi+1])
      );
   end

   // ---- S2: result stage ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_res_valid <= 1'b0;
         r_res_sum   <= '0;
         r_res_id    <= '0;
      end else if (w_adv2) begin
         r_res_valid <= r_s1_v;
         if (r_s1_v) begin
            r_res_sum <= {w_carry[WIDTH], w_sum};
            r_res_id  <= r_s1_id;
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_sum   = r_res_sum;
   assign res_id    = r_res_id;

endmodule

// File: tb/tb_rca_arbiter.sv
// Directed bench for rca_arbiter (N_REQ=4, WIDTH=4) with an in-order result scoreboard.
module tb_rca_arbiter;

   typedef struct {
      int         id;
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic       last;
   } op_t;

   typedef struct {
      int         id;
      logic [4:0] sum;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_cin;
`ifdef ADD_ARB_CHAIN_EN
   logic [3:0]  req_last;
`endif
   logic        res_valid;
   logic        res_ready;
   logic [4:0]  res_sum;
   logic [1:0]  res_id;

   op_t  pend[$];
   res_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic [3:0] acc;

   always #5 clk = ~clk;

   rca_arbiter #(
      .N_REQ (4),
      .WIDTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
`ifdef ADD_ARB_CHAIN_EN
      .req_last  (req_last),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_id    (res_id)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [4:0] sum5(input logic [3:0] a, input logic [3:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {4'b0, c};
   endfunction

   function automatic logic [3:0] t2a(input int i, input int r);
      return 4'((i * 3 + r * 5) % 16);
   endfunction

   task automatic add_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic last);
      op_t o;
      o.id = id; o.a = a; o.b = b; o.cin = cin; o.last = last;
      pend.push_back(o);
   endtask

   task automatic add_exp(input int id, input logic [4:0] sum);
      res_t r;
      r.id = id; r.sum = sum;
      exp_q.push_back(r);
   endtask

   // Each requester presents its oldest pending op and holds it until accepted.
   task automatic drive();
      logic [3:0]  v;
      logic [3:0]  c;
      logic [3:0]  l;
      logic [15:0] a;
      logic [15:0] b;
      int          i;
      v = '0; c = '0; l = '0; a = '0; b = '0;
      for (int k = 0; k < pend.size(); k++) begin
         i = pend[k].id;
         if (!v[i]) begin
            v[i]         = 1'b1;
            a[i*4 +: 4]  = pend[k].a;
            b[i*4 +: 4]  = pend[k].b;
            c[i]         = pend[k].cin;
            l[i]         = pend[k].last;
         end
      end
      req_valid = v;
      req_a     = a;
      req_b     = b;
      req_cin   = c;
`ifdef ADD_ARB_CHAIN_EN
      req_last  = l;
`endif
      #1;
   endtask

   task automatic remove_first(input int id);
      for (int k = 0; k < pend.size(); k++) begin
         if (pend[k].id == id) begin
            pend.delete(k);
            break;
         end
      end
   endtask

   task automatic tick();
      res_t r;
      @(negedge clk);
      acc = req_ready;
      if (res_valid && res_ready) begin
         chk("res_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("res_id", res_id, r.id);
            chk("res_sum", res_sum, r.sum);
         end
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++) if (acc[i]) remove_first(i);
      #1;
      drive();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || pend.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_empty", exp_q.size() + pend.size(), 0);
   endtask

   initial begin
      int cyc;
      res_ready = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
`ifdef ADD_ARB_CHAIN_EN
      req_last  = '0;
`endif

      // Reset state, with requests raised while reset is held
      repeat (2) @(posedge clk);
      #1;
      req_valid = 4'b1001;
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive();
      tick();

      // Test 1: single op, 9+8+1
      add_op(0, 4'h9, 4'h8, 1'b1, 1'b1);
      add_exp(0, 5'h12);
      drive();
      chk("t1_grant", req_ready, 4'b0001);
      tick();
      chk("t1_s1_only", res_valid, 0);
      tick();
      chk("t1_valid", res_valid, 1);
      chk("t1_sum", res_sum, 5'h12);
      chk("t1_id", res_id, 0);
      drain(10);

      // Test 2: all four held valid, pointer starts at 1
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++)
            add_op(i, t2a(i, r), 4'(15 - i), 1'(r), 1'b1);
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 4; k++)
            add_exp((1 + k) % 4, sum5(t2a((1 + k) % 4, r), 4'(15 - ((1 + k) % 4)), 1'(r)));
      drive();
      chk("t2_first_grant", req_ready, 4'b0010);
      cyc = 0;
      while (pend.size() > 0 && cyc < 30) begin
         tick();
         cyc++;
      end
      chk("t2_accept_cycles", cyc, 8);
      drain(10);

      // Test 3: backpressure fills S1 and S2, then release
      res_ready = 1'b0;
      add_op(1, 4'h3, 4'h4, 1'b0, 1'b1);
      add_op(2, 4'hF, 4'hF, 1'b1, 1'b1);
      add_op(3, 4'h1, 4'h1, 1'b0, 1'b1);
      add_exp(1, 5'h07);
      add_exp(2, 5'h1F);
      add_exp(3, 5'h02);
      drive();
      tick();
      tick();
      chk("t3_ready_stall", req_ready, 0);
      chk("t3_valid", res_valid, 1);
      chk("t3_sum", res_sum, 5'h07);
      chk("t3_id", res_id, 1);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("t3_hold_valid", res_valid, 1);
         chk("t3_hold_sum", res_sum, 5'h07);
         chk("t3_hold_id", res_id, 1);
         chk("t3_hold_ready", req_ready, 0);
      end
      res_ready = 1'b1;
      drain(20);

      // Test 4: pointer follows last accept
      add_op(2, 4'h2, 4'h2, 1'b0, 1'b1);
      add_exp(2, 5'h04);
      drive();
      chk("t4_grant2", req_ready, 4'b0100);
      tick();
      add_op(1, 4'h5, 4'h5, 1'b0, 1'b1);
      add_op(3, 4'h7, 4'h8, 1'b1, 1'b1);
      add_exp(3, 5'h10);
      add_exp(1, 5'h0A);
      drive();
      chk("t4_grant3", req_ready, 4'b1000);
      drain(20);

      // Test 5: reset with S1 and S2 full
      res_ready = 1'b0;
      add_op(0, 4'h1, 4'h1, 1'b0, 1'b1);
      add_op(1, 4'h2, 4'h2, 1'b0, 1'b1);
      drive();
      tick();
      tick();
      chk("t5_pre_valid", res_valid, 1);
      rst = 1'b0;
      #1;
      chk("t5_rst_valid", res_valid, 0);
      chk("t5_rst_sum", res_sum, 0);
      chk("t5_rst_id", res_id, 0);
      chk("t5_rst_ready", req_ready, 0);
      pend.delete();
      exp_q.delete();
      drive();
      tick();
      rst = 1'b1;
      res_ready = 1'b1;
      add_op(0, 4'h6, 4'h2, 1'b1, 1'b1);
      add_op(3, 4'h4, 4'h4, 1'b0, 1'b1);
      add_exp(0, 5'h09);
      add_exp(3, 5'h08);
      drive();
      tick();
      chk("t5_grant0", req_ready, 4'b0001);
      drain(20);

`ifdef ADD_ARB_CHAIN_EN
      // Test 6: chained two-beat op from req1 keeps req0 waiting
      add_op(0, 4'h1, 4'h0, 1'b0, 1'b1);
      add_exp(0, 5'h01);
      drive();
      tick();
      add_op(1, 4'hF, 4'h1, 1'b0, 1'b0);
      add_op(1, 4'h0, 4'h0, 1'b0, 1'b1);
      add_op(0, 4'h2, 4'h3, 1'b0, 1'b1);
      add_exp(1, 5'h10);
      add_exp(1, 5'h01);
      add_exp(0, 5'h05);
      drive();
      chk("t6_grant1", req_ready, 4'b0010);
      tick();
      chk("t6_locked", req_ready, 4'b0010);
      drain(20);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
